// File: rtl/spi_dword_interface.sv
// spi_dword_interface
//   Bridges a 32-bit host write port to an N25Q-class SPI NOR flash. The host
//   writes a header dword (opcode, payload dword count, quad flag) followed by
//   the payload dwords. Payload is buffered in a FIFO and streamed out as one
//   chip-select frame in 1-bit extended SPI or 4-bit quad protocol. Read-type
//   opcodes append an 8-bit read phase whose result lands on readout.
//
// Ports
//   clk62        in     system clock (62.5 MHz)
//   RESET_n      in     asynchronous active-low reset
//   data_from_PC in  32 header or payload dword
//   wr           in     one-cycle strobe qualifying data_from_PC
//   busy         out    frame in progress (header latched until back in IDLE)
//   error        out    sticky protocol error (unexpected or overflowing payload)
//   readout      out 8  last byte read from the flash
//   C            out    SPI clock, idles low (mode 0)
//   S            out    chip select, active low
//   DQio         inout 4 {DQ3/HOLD#, DQ2/W#, DQ1, DQ0}
module spi_dword_interface #(
  parameter int FIFO_DEPTH = 128,
  parameter int SCK_DIV    = 2,
  parameter int CS_IDLE    = 4
) (
  input  logic        clk62,
  input  logic        RESET_n,
  input  logic [31:0] data_from_PC,
  input  logic        wr,
  output logic        busy,
  output logic        error,
  output logic [7:0]  readout,
  output logic        C,
  output logic        S,
  inout  wire  [3:0]  DQio
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(SCK_DIV);
  localparam int IW = $clog2(CS_IDLE + 1);
  localparam logic [DW-1:0] HALF_M1 = DW'(SCK_DIV / 2 - 1);
  localparam logic [IW-1:0] IDLE_M1 = IW'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CS_SETUP, ST_SHIFT, ST_READ, ST_CS_HOLD, ST_CS_IDLE
  } state_t;

  state_t state_q, state_d;

  logic [7:0]    opcode_q, opcode_d;
  logic [7:0]    count_q, count_d;
  logic          quad_q, quad_d;
  logic [7:0]    rxCnt_q, rxCnt_d;
  logic [7:0]    txCnt_q, txCnt_d;
  logic [31:0]   shReg_q, shReg_d;
  logic [5:0]    bitsLeft_q, bitsLeft_d;
  logic          haveData_q, haveData_d;
  logic [DW-1:0] divCnt_q, divCnt_d;
  logic          sck_q, sck_d;
  logic [3:0]    rdLeft_q, rdLeft_d;
  logic [7:0]    rdShift_q, rdShift_d;
  logic [7:0]    readout_q, readout_d;
  logic          error_q, error_d;
  logic [IW-1:0] idleCnt_q, idleCnt_d;
  logic [AW:0]   wrPtr_q, wrPtr_d;
  logic [AW:0]   rdPtr_q, rdPtr_d;

  logic [31:0] fifoMem [FIFO_DEPTH];
  logic [31:0] fifoHead;
  logic        fifoEmpty, fifoFull;

  logic        isByteOp, isAddrOp, isReadOp;
  logic        moreWords, clkRun, tick, riseEv, fallEv, lastBit;
  logic        push, loadNow;
  logic [5:0]  step;
  logic [3:0]  rdStep;
  logic [31:0] chunkData;
  logic [5:0]  chunkBits;
  logic [3:0]  dqOut, dqOe;

  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign fifoHead  = fifoMem[rdPtr_q[AW-1:0]];

  assign isByteOp = (opcode_q == 8'h61) || (opcode_q == 8'h01) || (opcode_q == 8'h81);
  assign isAddrOp = (opcode_q == 8'h02) || (opcode_q == 8'h32);
  assign isReadOp = (opcode_q == 8'h9F) || (opcode_q == 8'hAF) ||
                    (opcode_q == 8'h05) || (opcode_q == 8'h70);

  assign step   = quad_q ? 6'd4 : 6'd1;
  assign rdStep = quad_q ? 4'd4 : 4'd1;

  // The bit clock only runs while there is something to shift or read;
  // with no data in hand the engine parks with C low.
  assign moreWords = (txCnt_q != count_q);
  assign clkRun    = ((state_q == ST_SHIFT) && haveData_q) || (state_q == ST_READ);
  assign tick      = clkRun && (divCnt_q == HALF_M1);
  assign riseEv    = tick && !sck_q;
  assign fallEv    = tick && sck_q;
  assign lastBit   = (bitsLeft_q == step);

  // A payload word is accepted only while the frame still expects one and
  // the FIFO has room; anything else is dropped and flagged.
  assign push    = wr && (state_q != ST_IDLE) && (rxCnt_q != count_q) && !fifoFull;
  assign loadNow = (state_q == ST_SHIFT) && moreWords && !fifoEmpty &&
                   (!haveData_q || (fallEv && lastBit));

  // Per-opcode framing of the FIFO head word, left-aligned for MSB-first shifting.
  always_comb begin
    chunkData = fifoHead;
    chunkBits = 6'd32;
    if (isByteOp) begin
      chunkData = {fifoHead[7:0], 24'h0};
      chunkBits = 6'd8;
    end else if (isAddrOp && (txCnt_q == 8'd0)) begin
      chunkData = {fifoHead[23:0], 8'h0};
      chunkBits = 6'd24;
    end
  end

  always_ff @(posedge clk62) begin
    if (push) fifoMem[wrPtr_q[AW-1:0]] <= data_from_PC;
  end

  // FSM state register
  always_ff @(posedge clk62 or negedge RESET_n) begin
    if (!RESET_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (wr) state_d = ST_CS_SETUP;
      ST_CS_SETUP: state_d = ST_SHIFT;
      ST_SHIFT:    if (!haveData_q && !moreWords) state_d = isReadOp ? ST_READ : ST_CS_HOLD;
      ST_READ:     if (fallEv && (rdLeft_q == 4'd0)) state_d = ST_CS_HOLD;
      ST_CS_HOLD:  state_d = ST_CS_IDLE;
      ST_CS_IDLE:  if (idleCnt_q == IDLE_M1) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: chip select, busy and the pad drive pattern for DQ
  always_comb begin
    busy  = (state_q != ST_IDLE);
    S     = !((state_q == ST_CS_SETUP) || (state_q == ST_SHIFT) ||
              (state_q == ST_READ) || (state_q == ST_CS_HOLD));
    dqOut = 4'b1100;
    dqOe  = 4'b1111;
    unique case (state_q)
      ST_CS_SETUP, ST_SHIFT: begin
        if (quad_q) begin
          dqOut = shReg_q[31:28];
        end else begin
          dqOut = {3'b110, shReg_q[31]};
          dqOe  = 4'b1101;
        end
      end
      ST_READ:    dqOe = quad_q ? 4'b0000 : 4'b1101;
      // Keep the flash's read lanes released until S rises.
      ST_CS_HOLD: begin
        if (quad_q && isReadOp) dqOe = 4'b0000;
        else if (!quad_q)       dqOe = 4'b1101;
      end
      default: ;
    endcase
  end

  assign DQio[0] = dqOe[0] ? dqOut[0] : 1'bz;
  assign DQio[1] = dqOe[1] ? dqOut[1] : 1'bz;
  assign DQio[2] = dqOe[2] ? dqOut[2] : 1'bz;
  assign DQio[3] = dqOe[3] ? dqOut[3] : 1'bz;

  // Datapath next-state: host intake, FIFO pointers, bit clock, shifter, read capture
  always_comb begin
    opcode_d   = opcode_q;
    count_d    = count_q;
    quad_d     = quad_q;
    rxCnt_d    = rxCnt_q;
    txCnt_d    = txCnt_q;
    shReg_d    = shReg_q;
    bitsLeft_d = bitsLeft_q;
    haveData_d = haveData_q;
    divCnt_d   = divCnt_q;
    sck_d      = sck_q;
    rdLeft_d   = rdLeft_q;
    rdShift_d  = rdShift_q;
    readout_d  = readout_q;
    error_d    = error_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    idleCnt_d  = (state_q == ST_CS_IDLE) ? idleCnt_q + 1'b1 : '0;

    // The opcode is preloaded so it is already on DQ during CS_SETUP.
    if (wr && (state_q == ST_IDLE)) begin
      opcode_d   = data_from_PC[7:0];
      count_d    = data_from_PC[15:8];
      quad_d     = data_from_PC[16];
      rxCnt_d    = '0;
      txCnt_d    = '0;
      shReg_d    = {data_from_PC[7:0], 24'h0};
      bitsLeft_d = 6'd8;
      haveData_d = 1'b1;
      divCnt_d   = '0;
      sck_d      = 1'b0;
    end else if (wr && !push) begin
      error_d = 1'b1;
    end

    if (push) begin
      wrPtr_d = wrPtr_q + 1'b1;
      rxCnt_d = rxCnt_q + 1'b1;
    end

    if (clkRun) begin
      if (tick) begin
        divCnt_d = '0;
        sck_d    = ~sck_q;
      end else begin
        divCnt_d = divCnt_q + 1'b1;
      end
    end

    // New data is presented on the falling edge so the flash sees it stable at the rise.
    if ((state_q == ST_SHIFT) && fallEv) begin
      if (lastBit) begin
        haveData_d = 1'b0;
      end else begin
        shReg_d    = quad_q ? {shReg_q[27:0], 4'h0} : {shReg_q[30:0], 1'b0};
        bitsLeft_d = bitsLeft_q - step;
      end
    end

    if (loadNow) begin
      shReg_d    = chunkData;
      bitsLeft_d = chunkBits;
      haveData_d = 1'b1;
      txCnt_d    = txCnt_q + 1'b1;
      rdPtr_d    = rdPtr_q + 1'b1;
      divCnt_d   = '0;
    end

    if ((state_q == ST_SHIFT) && (state_d == ST_READ)) begin
      rdLeft_d  = 4'd8;
      rdShift_d = '0;
    end

    if ((state_q == ST_READ) && riseEv) begin
      rdShift_d = quad_q ? {rdShift_q[3:0], DQio} : {rdShift_q[6:0], DQio[1]};
      rdLeft_d  = rdLeft_q - rdStep;
    end

    if ((state_q == ST_READ) && (state_d == ST_CS_HOLD)) readout_d = rdShift_q;
  end

  // Datapath registers; reset also flushes the FIFO and aborts any frame.
  always_ff @(posedge clk62 or negedge RESET_n) begin
    if (!RESET_n) begin
      opcode_q   <= '0;
      count_q    <= '0;
      quad_q     <= 1'b0;
      rxCnt_q    <= '0;
      txCnt_q    <= '0;
      shReg_q    <= '0;
      bitsLeft_q <= '0;
      haveData_q <= 1'b0;
      divCnt_q   <= '0;
      sck_q      <= 1'b0;
      rdLeft_q   <= '0;
      rdShift_q  <= '0;
      readout_q  <= '0;
      error_q    <= 1'b0;
      idleCnt_q  <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
    end else begin
      opcode_q   <= opcode_d;
      count_q    <= count_d;
      quad_q     <= quad_d;
      rxCnt_q    <= rxCnt_d;
      txCnt_q    <= txCnt_d;
      shReg_q    <= shReg_d;
      bitsLeft_q <= bitsLeft_d;
      haveData_q <= haveData_d;
      divCnt_q   <= divCnt_d;
      sck_q      <= sck_d;
      rdLeft_q   <= rdLeft_d;
      rdShift_q  <= rdShift_d;
      readout_q  <= readout_d;
      error_q    <= error_d;
      idleCnt_q  <= idleCnt_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
    end
  end

  assign C       = sck_q;
  assign error   = error_q;
  assign readout = readout_q;

endmodule

// File: tb/tb_spi_dword_interface.sv
// tb_spi_dword_interface
//   Drives host header/payload dwords into spi_dword_interface and decodes the
//   SPI frames with a small N25Q-style flash model (RDID, WREN/WRDI, WRVECR,
//   page program with page wrap). Expected frame bytes and C pulse counts are
//   queued as each command is issued and compared when the frame closes.
module tb_spi_dword_interface;

  logic        clk62 = 1'b0;
  logic        RESET_n = 1'b0;
  logic [31:0] data_from_PC = '0;
  logic        wr = 1'b0;
  wire         busy, error, C, S;
  wire  [7:0]  readout;
  wire  [3:0]  DQio;

  int errorCount = 0;
  int checkCount = 0;

  logic [31:0] payload [$];
  logic [7:0]  expBytes [$];
  int          expLen [$];
  int          expRise [$];

  // Flash model state
  logic [3:0]  flashOe = 4'h0;
  logic [3:0]  flashDq = 4'h0;
  logic [7:0]  vecr = 8'hDF;
  logic        wel = 1'b0;
  logic [7:0]  flashMem [logic [23:0]];
  logic [7:0]  frameBytes [$];
  logic [7:0]  cur;
  logic [7:0]  rdData;
  int          nb, rdIdx, mRise;
  logic        mInFrame = 1'b0;
  logic        mRead = 1'b0;
  logic        mQuad = 1'b0;
  logic        ignoreFrame = 1'b0;

  spi_dword_interface #(.FIFO_DEPTH(128), .SCK_DIV(2), .CS_IDLE(4)) dut (
    .clk62(clk62), .RESET_n(RESET_n), .data_from_PC(data_from_PC), .wr(wr),
    .busy(busy), .error(error), .readout(readout), .C(C), .S(S), .DQio(DQio)
  );

  assign DQio[0] = flashOe[0] ? flashDq[0] : 1'bz;
  assign DQio[1] = flashOe[1] ? flashDq[1] : 1'bz;
  assign DQio[2] = flashOe[2] ? flashDq[2] : 1'bz;
  assign DQio[3] = flashOe[3] ? flashDq[3] : 1'bz;

  always #8 clk62 = ~clk62;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic bit isReadOpcode(input logic [7:0] op);
    return (op == 8'h9F) || (op == 8'hAF) || (op == 8'h05) || (op == 8'h70);
  endfunction

  // Flash model: frame opens on S falling; quad decode follows VECR bit 7 (0 = quad).
  always @(negedge S) begin
    mInFrame = 1'b1;
    mRead    = 1'b0;
    mQuad    = ~vecr[7];
    mRise    = 0;
    nb       = 0;
    cur      = 8'h00;
    frameBytes.delete();
  end

  always @(posedge C) begin
    if (mInFrame) begin
      mRise++;
      if (!mRead) begin
        if (mQuad) begin
          cur = {cur[3:0], DQio};
          nb += 4;
        end else begin
          cur = {cur[6:0], DQio[0]};
          nb += 1;
        end
        if (nb == 8) begin
          frameBytes.push_back(cur);
          nb = 0;
          if ((frameBytes.size() == 1) && (cur == 8'h9F)) begin
            mRead  = 1'b1;
            rdIdx  = 0;
            rdData = 8'h20;
          end
        end
      end
    end
  end

  always @(negedge C) begin
    if (mInFrame && mRead && (rdIdx < 8)) begin
      if (mQuad) begin
        flashOe = 4'hF;
        flashDq = (rdIdx == 0) ? rdData[7:4] : rdData[3:0];
        rdIdx += 4;
      end else begin
        flashOe = 4'b0010;
        flashDq = {2'b00, rdData[7 - rdIdx], 1'b0};
        rdIdx += 1;
      end
    end
  end

  // Frame close: pop the scoreboard, compare, then apply the command's effect.
  always @(posedge S) begin
    logic [23:0] addr, a;
    logic [7:0]  e;
    logic [31:0] got;
    int          len, rise;
    flashOe = 4'h0;
    mRead   = 1'b0;
    if (mInFrame) begin
      mInFrame = 1'b0;
      if (!ignoreFrame) begin
        checkOutput("sb_pending", 32'(expLen.size() > 0), 32'd1);
        if (expLen.size() > 0) begin
          len  = expLen.pop_front();
          rise = expRise.pop_front();
          checkOutput("frame_len", frameBytes.size(), len);
          checkOutput("frame_rise", mRise, rise);
          for (int i = 0; i < len; i++) begin
            e   = expBytes.pop_front();
            got = (i < frameBytes.size()) ? 32'(frameBytes[i]) : 32'hDEAD_BEEF;
            checkOutput("frame_byte", got, 32'(e));
          end
        end
        if (frameBytes.size() > 0) begin
          case (frameBytes[0])
            8'h06: wel = 1'b1;
            8'h04: wel = 1'b0;
            8'h61: if (frameBytes.size() >= 2) vecr = frameBytes[1];
            8'h02, 8'h32: begin
              if (wel && (frameBytes.size() >= 4)) begin
                addr = {frameBytes[1], frameBytes[2], frameBytes[3]};
                for (int k = 4; k < frameBytes.size(); k++) begin
                  a = addr;
                  a[7:0] = addr[7:0] + 8'(k - 4);
                  flashMem[a] = frameBytes[k];
                end
                wel = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Queue the expected frame, write header + payload, then wait for busy to drop.
  task automatic applyStimulus(input logic [31:0] hdr, input int gap);
    logic [7:0]  op;
    logic [31:0] w;
    int          n, bytes, perByte, cyc;
    op    = hdr[7:0];
    n     = int'(hdr[15:8]);
    bytes = 1;
    expBytes.push_back(op);
    for (int i = 0; (i < n) && (i < payload.size()); i++) begin
      w = payload[i];
      if ((op == 8'h61) || (op == 8'h01) || (op == 8'h81)) begin
        expBytes.push_back(w[7:0]);
        bytes += 1;
      end else if (((op == 8'h02) || (op == 8'h32)) && (i == 0)) begin
        expBytes.push_back(w[23:16]);
        expBytes.push_back(w[15:8]);
        expBytes.push_back(w[7:0]);
        bytes += 3;
      end else begin
        expBytes.push_back(w[31:24]);
        expBytes.push_back(w[23:16]);
        expBytes.push_back(w[15:8]);
        expBytes.push_back(w[7:0]);
        bytes += 4;
      end
    end
    perByte = hdr[16] ? 2 : 8;
    expLen.push_back(bytes);
    expRise.push_back(bytes * perByte + (isReadOpcode(op) ? perByte : 0));

    @(negedge clk62);
    data_from_PC = hdr;
    wr = 1'b1;
    @(negedge clk62);
    wr = 1'b0;
    checkOutput("busy_rise", busy, 1);
    checkOutput("cs_active", S, 0);
    for (int i = 0; i < payload.size(); i++) begin
      repeat (gap - 1) @(negedge clk62);
      data_from_PC = payload[i];
      wr = 1'b1;
      @(negedge clk62);
      wr = 1'b0;
    end
    cyc = 0;
    while (busy && (cyc < 8000)) begin
      @(negedge clk62);
      cyc++;
    end
    checkOutput("busy_fall", busy, 0);
    checkOutput("cs_idle", S, 1);
    checkOutput("c_idle", C, 0);
  endtask

  initial begin
    logic [7:0] b;
    logic [23:0] a;
    logic [31:0] mv;

    // Hold reset while the flash model powers up.
    RESET_n = 1'b0;
    repeat (6) @(negedge clk62);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_s", S, 1);
    checkOutput("rst_c", C, 0);
    checkOutput("rst_error", error, 0);
    checkOutput("rst_readout", readout, 8'h00);
    checkOutput("rst_dq", DQio, 4'b1100);
    RESET_n = 1'b1;
    @(negedge clk62);

    $display("[TB] RDID, 1-bit");
    payload.delete();
    applyStimulus(32'h0000_009F, 1);
    checkOutput("readout_rdid", readout, 8'h20);

    $display("[TB] WRVECR 0x4F, 1-bit");
    payload.delete();
    payload.push_back(32'h0000_004F);
    applyStimulus(32'h0000_0161, 1);
    checkOutput("vecr", vecr, 8'h4F);
    checkOutput("error_wrvecr", error, 0);

    $display("[TB] WREN, quad");
    payload.delete();
    applyStimulus(32'h0001_0006, 1);
    checkOutput("wel_set", wel, 1);

    $display("[TB] page program, quad, 64 data words");
    payload.delete();
    payload.push_back(32'h00AB_CDEF);
    for (int i = 0; i < 64; i++) begin
      b = 8'(i);
      payload.push_back({b, b, b, b});
    end
    applyStimulus(32'h0001_4102, 2);
    checkOutput("error_pp", error, 0);
    checkOutput("wel_clear", wel, 0);
    checkOutput("readout_hold", readout, 8'h20);
    for (int k = 0; k < 256; k++) begin
      a = {16'hABCD, 8'(8'hEF + 8'(k))};
      mv = flashMem.exists(a) ? 32'(flashMem[a]) : 32'h0000_01FF;
      checkOutput("page_byte", mv, 32'(k / 4));
    end

    $display("[TB] payload overrun");
    payload.delete();
    payload.push_back(32'h1234_5678);
    payload.push_back(32'h9ABC_DEF0);
    applyStimulus(32'h0001_01AB, 2);
    checkOutput("error_set", error, 1);
    repeat (20) @(negedge clk62);
    checkOutput("error_sticky", error, 1);

    $display("[TB] reset mid-frame");
    ignoreFrame = 1'b1;
    @(negedge clk62);
    data_from_PC = 32'h0001_02AB;
    wr = 1'b1;
    @(negedge clk62);
    wr = 1'b0;
    repeat (10) @(negedge clk62);
    checkOutput("stall_cs", S, 0);
    checkOutput("stall_busy", busy, 1);
    RESET_n = 1'b0;
    #1;
    checkOutput("abort_s", S, 1);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_c", C, 0);
    checkOutput("abort_error", error, 0);
    checkOutput("abort_readout", readout, 8'h00);
    repeat (4) @(negedge clk62);
    ignoreFrame = 1'b0;
    RESET_n = 1'b1;
    @(negedge clk62);

    $display("[TB] RDID, quad");
    payload.delete();
    applyStimulus(32'h0001_009F, 1);
    checkOutput("readout_qrdid", readout, 8'h20);
    checkOutput("error_final", error, 0);

    checkOutput("sb_drained", expLen.size(), 0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
